// File: rtl/bus_map_pkg.sv
// Shared definitions for the CPU-side memory responder.
//   state_t          : responder FSM states (IDLE, LOAD, RUN, HALT)
//   IO_PAGE_DEFAULT  : default value of address[31:28] selecting the I/O page
//   IO_OUT..IO_HALT  : word offsets (address[1:0]) of the I/O registers
package bus_map_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [3:0] IO_PAGE_DEFAULT = 4'hF;

    localparam logic [1:0] IO_OUT    = 2'd0;
    localparam logic [1:0] IO_CYCLES = 2'd1;
    localparam logic [1:0] IO_STATUS = 2'd2;
    localparam logic [1:0] IO_HALT   = 2'd3;

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous RAM of 32-bit words.
// Write-first: on a write cycle the read register takes the written word.
// Registered read, no reset (contents and read register power up unknown).
//   clock : rising-edge clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module word_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side responder for the CPU word bus.
// Accepts a program image through a valid/ready load port, then releases the
// CPU (cpu_run) and serves its reads/writes from on-chip RAM plus a small
// memory-mapped I/O page (output port, cycle counter, status, halt).
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   address, cpu_wdata, rw: CPU bus (rw=1 read, rw=0 write)
//   cpu_rdata             : read data, registered, valid the cycle after request
//   cpu_run               : CPU may execute
//   load_valid/data/last  : program-image beat, load_ready accepts it
//   io_out, io_strobe     : output-port register and its write pulse
//   bus_error             : sticky unmapped-access flag
module bus_memory_responder
    import bus_map_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [3:0] IO_PAGE    = IO_PAGE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] cpu_wdata,
    input  logic        rw,
    output logic [31:0] cpu_rdata,
    output logic        cpu_run,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic [31:0] io_out,
    output logic        io_strobe,
    output logic        bus_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    state_t                state;
    state_t                state_next;
    logic                  armed;
    logic [ADDR_WIDTH-1:0] load_ptr;
    logic [31:0]           cycles;
    logic                  load_fire;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    logic                  ram_hit;
    logic                  io_hit;
    logic [1:0]            io_off;
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [31:0]           io_rd_value;

    logic                  rd_ram_q;
    logic [31:0]           rdata_q;

    assign ram_hit = (address[31:ADDR_WIDTH] == '0);
    assign io_hit  = !ram_hit && (address[31:28] == IO_PAGE);
    assign io_off  = address[1:0];

    // FSM next state, port ownership and handshake outputs.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        cpu_run    = 1'b0;
        load_fire  = 1'b0;
        cpu_rd     = 1'b0;
        cpu_wr     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = address[ADDR_WIDTH-1:0];
        ram_wdata  = cpu_wdata;
        case (state)
            IDLE, LOAD: begin
                // armed keeps ready low until the first edge after reset release
                load_ready = armed;
                load_fire  = load_valid && armed;
                ram_addr   = load_ptr;
                ram_wdata  = load_data;
                ram_we     = load_fire;
                if (load_fire) begin
                    if (load_last || (load_ptr == LAST_PTR)) begin
                        state_next = RUN;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            RUN: begin
                cpu_run = 1'b1;
                cpu_rd  = rw;
                cpu_wr  = !rw;
                ram_we  = cpu_wr && ram_hit;
                if (cpu_wr && io_hit && (io_off == IO_HALT)) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        io_rd_value = '0;
        case (io_off)
            IO_OUT:    io_rd_value = io_out;
            IO_CYCLES: io_rd_value = cycles;
            IO_STATUS: io_rd_value = 32'd1;
            default:   io_rd_value = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // Pointer saturates at the last word; reaching it ends the load anyway.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_ptr <= '0;
        end else if (load_fire && (load_ptr != LAST_PTR)) begin
            load_ptr <= load_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (state == RUN) begin
            cycles <= cycles + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_out    <= '0;
            io_strobe <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            io_strobe <= 1'b0;
            if (cpu_wr && io_hit && (io_off == IO_OUT)) begin
                io_out    <= cpu_wdata;
                io_strobe <= 1'b1;
            end
            if ((cpu_rd || cpu_wr) && !ram_hit && !io_hit) begin
                bus_error <= 1'b1;
            end
        end
    end

    // RAM reads are returned straight from the RAM's read register; any
    // other cycle snapshots the last RAM word so cpu_rdata holds across
    // writes (the write-first RAM would otherwise show the written word).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ram_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cpu_rd) begin
            if (ram_hit) begin
                rd_ram_q <= 1'b1;
            end else begin
                rd_ram_q <= 1'b0;
                rdata_q  <= io_hit ? io_rd_value : '0;
            end
        end else begin
            if (rd_ram_q) begin
                rdata_q <= ram_rdata;
            end
            rd_ram_q <= 1'b0;
        end
    end

    assign cpu_rdata = rd_ram_q ? ram_rdata : rdata_q;

    word_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed + randomized bench for bus_memory_responder with a behavioural
// model of RAM image, I/O page, run state and cycle count.
module tb_bus_memory_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] cpu_wdata;
    logic        rw;
    logic [31:0] cpu_rdata;
    logic        cpu_run;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [31:0] io_out;
    logic        io_strobe;
    logic        bus_error;

    bus_memory_responder #(.ADDR_WIDTH(AW), .IO_PAGE(4'hF)) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .cpu_wdata (cpu_wdata),
        .rw        (rw),
        .cpu_rdata (cpu_rdata),
        .cpu_run   (cpu_run),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .io_out    (io_out),
        .io_strobe (io_strobe),
        .bus_error (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem   [0:DEPTH-1];
    bit          m_valid [0:DEPTH-1];
    logic [31:0] m_io_out;
    logic [31:0] m_cycles;
    logic [31:0] m_rdata;
    bit          m_run;
    bit          m_err;
    int          m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (m_run) m_cycles++;
        #1;
    endtask

    task automatic model_reset();
        m_io_out = '0;
        m_cycles = '0;
        m_rdata  = '0;
        m_run    = 1'b0;
        m_err    = 1'b0;
        m_ptr    = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdata"},  cpu_rdata,  32'h0);
        check({tag, "_ioout"},  io_out,     32'h0);
        check({tag, "_strobe"}, io_strobe,  1'b0);
        check({tag, "_run"},    cpu_run,    1'b0);
        check({tag, "_ready"},  load_ready, 1'b0);
        check({tag, "_berr"},   bus_error,  1'b0);
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return (a >> AW) == 0;
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return !is_ram(a) && (a[31:28] == 4'hF);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (!m_run) return m_rdata;
        if (is_ram(a)) return m_mem[a % DEPTH];
        if (is_io(a)) begin
            case (a % 4)
                0: return m_io_out;
                1: return m_cycles;
                2: return 32'd1;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic load_beat(input logic [31:0] d, input logic last);
        address    = 32'h0;
        rw         = 1'b1;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        m_mem[m_ptr]   = d;
        m_valid[m_ptr] = 1'b1;
        if (last || m_ptr == DEPTH - 1) m_run = 1'b1;
        else m_ptr++;
    endtask

    task automatic cpu_read(input logic [31:0] a, input string tag);
        logic [31:0] exp;
        exp     = exp_read(a);
        address = a;
        rw      = 1'b1;
        step();
        if (m_run && !is_ram(a) && !is_io(a)) m_err = 1'b1;
        m_rdata = exp;
        check(tag, cpu_rdata, exp);
        check({tag, "_strobe"}, io_strobe, 1'b0);
        check({tag, "_berr"}, bus_error, m_err);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        bit exp_strobe;
        exp_strobe = m_run && is_io(a) && (a % 4 == 0);
        address    = a;
        cpu_wdata  = d;
        rw         = 1'b0;
        step();
        address = 32'h0;
        rw      = 1'b1;
        if (m_run) begin
            if (is_ram(a)) begin
                m_mem[a % DEPTH]   = d;
                m_valid[a % DEPTH] = 1'b1;
            end else if (is_io(a)) begin
                if (a % 4 == 0) m_io_out = d;
                if (a % 4 == 3) m_run = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        check({tag, "_hold"}, cpu_rdata, m_rdata);
        check({tag, "_strobe"}, io_strobe, exp_strobe);
        check({tag, "_berr"}, bus_error, m_err);
    endtask

    initial begin
        logic [31:0] c1;
        logic [31:0] a;
        logic [31:0] d;

        reset      = 1'b0;
        address    = 32'h0;
        cpu_wdata  = 32'h0;
        rw         = 1'b1;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        model_reset();

        repeat (2) step();
        check_reset_values("rst");

        reset = 1'b1;
        step();
        check("ready_after_rst", load_ready, 1'b1);
        check("run_after_rst", cpu_run, 1'b0);

        // Three-beat image
        load_beat(32'h11, 1'b0);
        load_beat(32'h22, 1'b0);
        check("ready_mid_load", load_ready, 1'b1);
        check("run_mid_load", cpu_run, 1'b0);
        load_beat(32'h33, 1'b1);
        check("ready_after_last", load_ready, 1'b0);
        check("run_after_last", cpu_run, 1'b1);

        cpu_read(32'h0, "rd0");
        cpu_read(32'h1, "rd1");
        cpu_read(32'h2, "rd2");

        cpu_write(32'h5, 32'hDEADBEEF, "wr5");
        cpu_read(32'h5, "rd5");

        // Random RAM traffic over a small window
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(31, 0);
            d = $urandom;
            if ($urandom_range(1, 0) == 1 || !m_valid[a]) cpu_write(a, d, "rnd_wr");
            else cpu_read(a, "rnd_rd");
        end

        // Output port, back-to-back writes
        cpu_write(32'hF000_0000, 32'hA, "out_a");
        check("io_out_a", io_out, 32'hA);
        cpu_write(32'hF000_0000, 32'hB, "out_b");
        check("io_out_b", io_out, 32'hB);
        cpu_read(32'hF000_0000, "rd_out");

        cpu_read(32'hF000_0002, "rd_status");
        cpu_read(32'hF000_0002 | ($urandom & 32'h0FFF_FFFC), "rd_status_mid");
        cpu_read(32'hF000_0003, "rd_halt_reg");

        // Cycle counter: two reads four cycles apart
        cpu_read(32'hF000_0001, "rd_cyc1");
        c1 = cpu_rdata;
        cpu_write(32'hF000_0001, $urandom, "wr_cyc");
        cpu_read(32'h0, "gap0");
        cpu_read(32'h1, "gap1");
        cpu_read(32'hF000_0001, "rd_cyc2");
        check("cyc_diff", cpu_rdata - c1, 32'd4);

        // Unmapped accesses
        cpu_write(32'h0000_0400, 32'h1234_5678, "wr_unmapped");
        cpu_read(32'h0, "rd0_after_unmapped");
        cpu_read(32'h0001_0000, "rd_unmapped");
        cpu_read(32'h2, "rd2_sticky");

        // Halt
        cpu_write(32'hF000_0003, $urandom, "wr_halt");
        check("run_after_halt", cpu_run, 1'b0);
        check("ready_after_halt", load_ready, 1'b0);
        cpu_write(32'hF000_0000, 32'h55, "out_in_halt");
        check("io_out_in_halt", io_out, 32'hB);

        // Asynchronous reset while halted
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_halt");
        step();
        #2 reset = 1'b1;
        step();
        check("ready_rel2", load_ready, 1'b1);

        // Full-depth image without load_last
        for (int i = 0; i < DEPTH; i++) begin
            load_beat($urandom, 1'b0);
            if (i == DEPTH - 2) begin
                check("ready_before_full", load_ready, 1'b1);
                check("run_before_full", cpu_run, 1'b0);
            end
        end
        check("run_after_full", cpu_run, 1'b1);
        check("ready_after_full", load_ready, 1'b0);
        cpu_read(DEPTH - 1, "rd_top");
        cpu_read(32'h0, "rd_bottom");
        for (int i = 0; i < 20; i++) cpu_read($urandom_range(DEPTH - 1, 0), "rnd_full_rd");
        cpu_read(32'hF000_0001, "rd_cyc_full");

        // Asynchronous reset mid-run
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_run");
        step();
        #2 reset = 1'b1;
        step();

        // Partial image, reset mid-load, then a one-beat image
        load_beat(32'h99, 1'b0);
        load_beat(32'h98, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_load");
        step();
        #2 reset = 1'b1;
        step();
        check("ready_rel3", load_ready, 1'b1);
        load_beat(32'h77, 1'b1);
        check("run_one_beat", cpu_run, 1'b1);
        cpu_read(32'h0, "rd_new0");
        cpu_read(32'h2, "rd_kept2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_memory_responder.md
# bus_memory_responder

Memory-side responder for the CPU's single-master word bus (address / datao / data / rw). It holds program and data words in on-chip RAM and exposes a small memory-mapped I/O page. Before the CPU runs, it accepts a program image through a valid/ready load port, and it gates CPU execution through `cpu_run`. It sits between the CPU and the top level, with one instance per CPU.

## Interface
- `ADDR_WIDTH`, default 10: RAM word-address width; depth = 2**ADDR_WIDTH words.
- `IO_PAGE`, default 4'hF: value of `address[31:28]` that selects the I/O page.
- `clock` in 1: single clock; every flop is on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Low clears all state immediately.
- `address` in 32: CPU word address.
- `cpu_wdata` in 32: CPU write data (the CPU's `datao`).
- `rw` in 1: 1 = read, 0 = write.
- `cpu_rdata` out 32: read data to the CPU's `data` input.
- `cpu_run` out 1: high while the CPU may execute; the top level holds the CPU reset while this is low.
- `load_valid` in 1, `load_data` in 32, `load_last` in 1: program-image beat.
- `load_ready` out 1: responder accepts a beat when `load_valid && load_ready`.
- `io_out` out 32: output-port register.
- `io_strobe` out 1: one-cycle pulse on each write to the output port.
- `bus_error` out 1: sticky flag for an access to an unmapped address.

## Operation
- FSM states: IDLE, LOAD, RUN, HALT. Reset enters IDLE.
- IDLE and LOAD:
  - `load_ready`=1, `cpu_run`=0; CPU bus inputs are ignored.
  - An accepted beat writes RAM[`load_ptr`], then `load_ptr`++. The first beat moves IDLE→LOAD.
  - An accepted beat with `load_last`=1 goes to RUN.
  - An accepted beat at `load_ptr` = depth−1 also goes to RUN even when `load_last`=0; the pointer never wraps.
- RUN: `load_ready`=0, `cpu_run`=1, and the load port is ignored. The bus is decoded every cycle:
  - RAM region, `address[31:ADDR_WIDTH]`==0: a read returns RAM[`address[ADDR_WIDTH-1:0]`]; a write stores `cpu_wdata`.
  - I/O page, `address[31:28]`==`IO_PAGE`, offset = `address[1:0]`, upper middle bits ignored:
    - Offset 0, output port: a write sets `io_out`=`cpu_wdata` and pulses `io_strobe`; a read returns `io_out`.
    - Offset 1, cycle counter: read-only; increments each RUN cycle and wraps at 2^32. Writes are ignored.
    - Offset 2, status: read returns {31'b0, 1'b1} (load done). Writes are ignored.
    - Offset 3, halt: a write of any value moves to HALT; a read returns 0.
  - Any other address: a read returns 0, a write is dropped, and `bus_error` is set. Only reset clears it.
- HALT: `cpu_run`=0, `load_ready`=0, bus ignored, cycle counter frozen. HALT exits only through reset.
- RAM contents are not cleared by reset. After reset, a new image overwrites RAM from word 0.

## Timing
- Reset values: `cpu_rdata`=0, `io_out`=0, `io_strobe`=0, `cpu_run`=0, `load_ready`=0 while `reset` is low, `bus_error`=0, counter=0, `load_ptr`=0.
- `load_ready` rises in the first cycle after `reset` deasserts.
- Read latency: 1 cycle. `cpu_rdata` is registered at the rising edge on which `rw`=1 and `address` are sampled, and stays valid for the whole following cycle; the CPU samples it on the falling edge.
- During a write cycle, and outside RUN, `cpu_rdata` holds its previous value.
- Writes commit at the sampling rising edge. A read of the same address in the next cycle returns the new value.
- `cpu_run` rises in the cycle after the final load beat is accepted. It falls in the cycle after the halt write.
- `io_strobe` is high for exactly the one cycle after the output-port write edge, including for back-to-back writes.
- A loader beat and a CPU access never both reach RAM in the same cycle; the FSM state selects the RAM port owner.
- Reset asserted mid-load or mid-run returns to IDLE asynchronously. A partial image is discarded logically.

## Structure
- Package `bus_map_pkg`:
  - FSM state enum (IDLE, LOAD, RUN, HALT).
  - `IO_PAGE` default.
  - I/O offsets: `IO_OUT`=0, `IO_CYCLES`=1, `IO_STATUS`=2, `IO_HALT`=3.
- Sub-module `word_ram`: single-port synchronous RAM, 32-bit words, `ADDR_WIDTH` parameter, write-first, registered read, no reset.
- Top level contains:
  - the FSM, `load_ptr`, and cycle counter;
  - address decode and the RAM port mux (loader vs CPU);
  - I/O registers and the read-data mux.

## Test plan
- Load 3 beats (0x11, 0x22, 0x33 with `load_last` on the third) → `load_ready` drops and `cpu_run`=1 one cycle later; CPU-side reads of addresses 0, 1, 2 return 0x11, 0x22, 0x33 each one cycle after the request.
- In RUN, write 0xDEADBEEF to address 5, then read address 5 in the next cycle → 0xDEADBEEF; `cpu_rdata` holds its value during the write cycle.
- Two back-to-back writes (0xA, then 0xB) to 0xF0000000 → `io_strobe` high for 2 cycles, `io_out`=0xB, and a read of 0xF0000000 returns 0xB.
- Read 0xF0000001 twice, 4 cycles apart → difference = 4. Then write 0xF0000003 → `cpu_run`=0 next cycle and the counter is frozen.
- Read 0x00010000 (ADDR_WIDTH=10) → `cpu_rdata`=0 and `bus_error`=1, staying set until reset. Stream 1024 beats with no `load_last` → RUN entered after beat 1024.
- Assert `reset` low mid-load after 2 beats → all outputs at reset values immediately. After release, a new 1-beat image is accepted at address 0.
